// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential LEGv8 ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

  // ctrl encodings (single-cycle ops keep the legacy datapath codes)
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_UDIV  = 4'b1010;

  // iterative core mode select
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ops that go through the N-cycle shift/accumulate core
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UDIV);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared N-cycle datapath: shift-add MUL (low half, LSB first) and restoring UDIV (MSB first).
// Latency: start at edge t, last step at edge t+N; done/res are combinational during that last cycle.
// Backpressure: none; the caller must not restart while a run is in progress.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] res
);

  // opx: multiplicand (shifts left) or divisor
  // opy: multiplier (shifts right) or dividend/quotient (shifts left)
  // acc: partial product or partial remainder
  logic          busy;
  logic          mode_q;
  logic [CW-1:0] cnt;
  logic [N-1:0]  opx, opy, acc;

  logic [N-1:0]  mul_acc_nxt;
  logic [N:0]    rem_sh, diff;
  logic          q_bit;
  logic [N-1:0]  rem_nxt, quo_nxt;

  // one step of either algorithm, evaluated every cycle
  always_comb begin
    mul_acc_nxt = acc + (opy[0] ? opx : '0);
    rem_sh      = {acc, opy[N-1]};
    diff        = rem_sh - {1'b0, opx};
    q_bit       = ~diff[N];
    rem_nxt     = q_bit ? diff[N-1:0] : rem_sh[N-1:0];
    quo_nxt     = {opy[N-2:0], q_bit};
    done        = busy && (cnt == CW'(N - 1));
    res         = (mode_q == MODE_DIV) ? quo_nxt : mul_acc_nxt;
  end

  // operand load on start, then exactly N steps
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      mode_q <= MODE_MUL;
      cnt    <= '0;
      opx    <= '0;
      opy    <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= '0;
      opx    <= (mode == MODE_DIV) ? b : a;
      opy    <= (mode == MODE_DIV) ? a : b;
      acc    <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (mode_q == MODE_DIV) begin
        acc <= rem_nxt;
        opy <= quo_nxt;
      end else begin
        acc <= mul_acc_nxt;
        opx <= {opx[N-2:0], 1'b0};
        opy <= {1'b0, opy[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered LEGv8 ALU with NZCV flags, iterative MUL (low half) and UDIV.
// Latency: single-cycle/illegal ops 1 cycle after accept, MUL/UDIV N+1 cycles after accept.
// Backpressure: one op in flight; in_ready only in IDLE, result and flags held while out_ready=0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         div0,
  output logic         illegal
);

  state_t        state, state_nxt;
  logic          accept;
  logic          load_sc, load_it;
  logic [3:0]    op_q;
  logic          bz_q;

  logic [N:0]    add_full, sub_full;
  logic [N-1:0]  sc_res;
  logic          sc_c, sc_v, sc_ill;

  logic          it_start, it_done;
  logic [N-1:0]  it_res, it_final;
  logic          it_div0;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign it_start  = accept && is_iter(ctrl);

  alu_iter_core #(
    .N  (N),
    .CW (CW)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (it_start),
    .mode  ((ctrl == OP_UDIV) ? MODE_DIV : MODE_MUL),
    .a     (a),
    .b     (b),
    .done  (it_done),
    .res   (it_res)
  );

  // single-cycle datapath and its C/V, straight from the live operands
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_ill   = 1'b0;
    case (ctrl)
      OP_AND:   sc_res = a & b;
      OP_ORR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = add_full[N-1:0];
        sc_c   = add_full[N];
        sc_v   = (a[N-1] == b[N-1]) && (add_full[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[N-1:0];
        sc_c   = sub_full[N];
        sc_v   = (a[N-1] != b[N-1]) && (sub_full[N-1] != a[N-1]);
      end
      OP_PASSB: sc_res = b;
      OP_NOR:   sc_res = ~(a | b);
      default:  sc_ill = 1'b1;
    endcase
  end

  // UDIV by zero returns 0 even though the core still ran its N steps
  always_comb begin
    it_div0  = (op_q == OP_UDIV) && bz_q;
    it_final = it_div0 ? '0 : it_res;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and output-register load strobes
  always_comb begin
    state_nxt = state;
    load_sc   = 1'b0;
    load_it   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ctrl == OP_MUL)       state_nxt = S_MUL;
          else if (ctrl == OP_UDIV) state_nxt = S_DIV;
          else begin
            state_nxt = S_DONE;
            load_sc   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (it_done) begin
          state_nxt = S_DONE;
          load_it   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // remember what the iterative op needs at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_AND;
      bz_q <= 1'b0;
    end else if (accept) begin
      op_q <= ctrl;
      bz_q <= (b == '0);
    end
  end

  // result/flag registers, written once on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else if (load_sc) begin
      result  <= sc_res;
      flag_n  <= sc_res[N-1];
      flag_z  <= (sc_res == '0);
      flag_c  <= sc_c;
      flag_v  <= sc_v;
      div0    <= 1'b0;
      illegal <= sc_ill;
    end else if (load_it) begin
      result  <= it_final;
      flag_n  <= it_final[N-1];
      flag_z  <= (it_final == '0);
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      div0    <= it_div0;
      illegal <= 1'b0;
    end else if (accept) begin
      // a new MUL/UDIV clears the sticky status of the previous op
      div0    <= 1'b0;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): directed literal cases plus randomized ops.
// A per-cycle compare step checks handshake, latency and outputs against an arithmetic model.
// out_ready is held, toggled by hand or randomized to exercise backpressure.
module tb_alu_seq;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   ctrl = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v, div0, illegal;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .div0      (div0),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] r;
    logic [3:0]   nzcv;
    logic         d0;
    logic         ill;
    int           lat;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t cur;
  bit   busy = 1'b0;
  bit   rst_seen = 1'b1;
  int   exp_cyc = 0;
  bit   rand_rdy = 1'b0;

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [3:0] op);
    exp_t   e;
    longint ua, ub, sa, sb, s, ss, smax, smin;
    logic   c, v;
    ua   = longint'(ia);
    ub   = longint'(ib);
    sa   = ia[N-1] ? ua - (longint'(1) << N) : ua;
    sb   = ib[N-1] ? ub - (longint'(1) << N) : ub;
    smax = (longint'(1) << (N-1)) - 1;
    smin = -(longint'(1) << (N-1));
    e    = '0;
    e.lat = 1;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: e.r = ia & ib;
      4'b0001: e.r = ia | ib;
      4'b0010: begin
        s   = ua + ub;
        e.r = s[N-1:0];
        c   = (s >= (longint'(1) << N));
        ss  = sa + sb;
        v   = (ss > smax) || (ss < smin);
      end
      4'b0110: begin
        s   = ua - ub;
        e.r = s[N-1:0];
        c   = (ua >= ub);
        ss  = sa - sb;
        v   = (ss > smax) || (ss < smin);
      end
      4'b0111: e.r = ib;
      4'b1100: e.r = ~(ia | ib);
      4'b1000: begin
        s     = ua * ub;
        e.r   = s[N-1:0];
        e.lat = N + 1;
      end
      4'b1010: begin
        e.lat = N + 1;
        if (ub == 0) begin
          e.r  = '0;
          e.d0 = 1'b1;
        end else begin
          s   = ua / ub;
          e.r = s[N-1:0];
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.nzcv = {e.r[N-1], (e.r == '0), c, v};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Per-cycle compare against the model, then advance the model
  task automatic monitor_step();
    bit exp_ov;
    exp_ov = busy && (cyc >= exp_cyc);
    if (rst_seen) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {flag_n, flag_z, flag_c, flag_v, div0, illegal}, 0);
    end else begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("result", result, cur.r);
        chk("nzcv", {flag_n, flag_z, flag_c, flag_v}, cur.nzcv);
        chk("div0", div0, cur.d0);
        chk("illegal", illegal, cur.ill);
      end
    end
    if (rst) begin
      busy = 1'b0;
    end else if (in_valid && !busy) begin
      cur     = model(a, b, ctrl);
      busy    = 1'b1;
      exp_cyc = cyc + cur.lat;
    end else if (exp_ov && out_ready) begin
      busy = 1'b0;
    end
    rst_seen = rst;
  endtask

  // Advance one clock; inputs change and driver samples 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    cyc++;
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [3:0] op);
    bit acc;
    bit ok;
    ok       = 1'b0;
    a        = ia;
    b        = ib;
    ctrl     = op;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept");
    in_valid = 1'b0;
    a        = N'($urandom);
    b        = N'($urandom);
    ctrl     = 4'($urandom);
  endtask

  task automatic expect_lit(input string name, input logic [N-1:0] r, input logic [3:0] nzcv,
                            input logic d0, input logic ill, input int lat_exp);
    int lat;
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout({name, "_valid"});
    chk({name, "_lat"}, lat, lat_exp);
    chk({name, "_r"}, result, r);
    chk({name, "_nzcv"}, {flag_n, flag_z, flag_c, flag_v}, nzcv);
    chk({name, "_div0"}, div0, d0);
    chk({name, "_ill"}, illegal, ill);
  endtask

  function automatic logic [N-1:0] pick_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return N'(8'h7F);
      2:       return N'(8'h80);
      3:       return N'(8'hFF);
      default: return N'($urandom);
    endcase
  endfunction

  logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1000, 4'b1010};

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_result", result, 0);

    // directed literal cases, consumer always ready
    do_op(8'h7F, 8'h01, 4'b0010); expect_lit("add_ovf",  8'h80, 4'b1001, 0, 0, 1);
    do_op(8'hFF, 8'h01, 4'b0010); expect_lit("add_wrap", 8'h00, 4'b0110, 0, 0, 1);
    do_op(8'h05, 8'h05, 4'b0110); expect_lit("sub_eq",   8'h00, 4'b0110, 0, 0, 1);
    do_op(8'h03, 8'h05, 4'b0110); expect_lit("sub_lt",   8'hFE, 4'b1000, 0, 0, 1);
    do_op(8'h0D, 8'h0B, 4'b1000); expect_lit("mul",      8'h8F, 4'b1000, 0, 0, N + 1);
    do_op(8'd200, 8'd7, 4'b1010); expect_lit("udiv",     8'd28, 4'b0000, 0, 0, N + 1);
    do_op(8'd5, 8'd0, 4'b1010);   expect_lit("udiv0",    8'h00, 4'b0100, 1, 0, N + 1);
    do_op(8'h01, 8'h01, 4'b0010); expect_lit("div0_clr", 8'h02, 4'b0000, 0, 0, 1);

    // illegal op under backpressure; a second op waits at the input
    tick();
    out_ready = 1'b0;
    do_op(8'hAA, 8'h55, 4'b0011);
    a        = 8'h10;
    b        = 8'h20;
    ctrl     = 4'b0010;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 0);
      chk("bp_illegal", illegal, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_result", result, 8'h30);
    chk("bp_held_illegal", illegal, 0);
    tick();

    // reset in the middle of a MUL: the op must vanish
    do_op(8'h0F, 8'h0F, 4'b1000);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {flag_n, flag_z, flag_c, flag_v, div0, illegal}, 0);
    for (int i = 0; i < N + 4; i++) begin
      tick();
      chk("midrst_no_stale", out_valid, 0);
    end

    // randomized ops with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      repeat ($urandom_range(0, 2)) tick();
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
      do_op(pick_opnd(), pick_opnd(), op);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (N + 6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
